// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32 control sequencer. It drives the shared memory port, the PC/IR write enables
// and the ALU/regfile controls, and traps on illegal opcodes or memory timeouts.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                alu_src,
  output logic [1:0]          aluop,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                illegal_instr,
  output logic                bus_error,
  output logic                retire_pulse,
  output logic [RETIRE_W-1:0] retire_count
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  // Counter value on the last permitted wait cycle; trapping happens if ready is still low.
  localparam logic [WaitW-1:0] WaitLast = (MEM_TIMEOUT == 0) ? '0 : WaitW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OpR  = 7'b0110011;
  localparam logic [6:0] OpI  = 7'b0010011;
  localparam logic [6:0] OpLd = 7'b0000011;
  localparam logic [6:0] OpSt = 7'b0100011;
  localparam logic [6:0] OpBr = 7'b1100011;

  localparam logic [1:0] AluAdd  = 2'b00;
  localparam logic [1:0] AluBr   = 2'b01;
  localparam logic [1:0] AluFunc = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWriteback,
    StBranch,
    StTrap
  } state_e;

  typedef enum logic [2:0] {
    ClsR,
    ClsI,
    ClsLd,
    ClsSt,
    ClsBr,
    ClsIll
  } cls_e;

  state_e              state_q, state_d;
  cls_e                cls_q, cls_d;
  cls_e                dec_cls;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;
  logic                illegal_q, illegal_d;
  logic                bus_q, bus_d;
  logic                cls_alu;
  logic                timeout_hit;

  always_comb begin
    case (opcode)
      OpR:     dec_cls = ClsR;
      OpI:     dec_cls = ClsI;
      OpLd:    dec_cls = ClsLd;
      OpSt:    dec_cls = ClsSt;
      OpBr:    dec_cls = ClsBr;
      default: dec_cls = ClsIll;
    endcase
  end

  assign cls_alu     = (cls_q == ClsR) || (cls_q == ClsI);
  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WaitLast);

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    wait_d       = '0;
    retire_d     = retire_q;
    illegal_d    = illegal_q;
    bus_d        = bus_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src      = 1'b0;
    aluop        = AluAdd;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    retire_pulse = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else if (timeout_hit) begin
          bus_d   = 1'b1;
          state_d = StTrap;
        end else if (MEM_TIMEOUT != 0) begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecode: begin
        cls_d = dec_cls;
        case (dec_cls)
          ClsBr:   state_d = StBranch;
          ClsIll: begin
            illegal_d = 1'b1;
            state_d   = StTrap;
          end
          default: state_d = StExecute;
        endcase
      end
      StExecute: begin
        alu_src = (cls_q != ClsR);
        aluop   = cls_alu ? AluFunc : AluAdd;
        state_d = cls_alu ? StWriteback : StMem;
      end
      StMem: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        alu_src = 1'b1;
        mem_we  = (cls_q == ClsSt);
        if (mem_ready) begin
          if (cls_q == ClsSt) retire_pulse = 1'b1;
          else                state_d      = StWriteback;
        end else if (timeout_hit) begin
          bus_d   = 1'b1;
          state_d = StTrap;
        end else if (MEM_TIMEOUT != 0) begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWriteback: begin
        reg_write    = 1'b1;
        mem_to_reg   = (cls_q == ClsLd);
        retire_pulse = 1'b1;
        if (cls_alu) begin
          alu_src = (cls_q == ClsI);
          aluop   = AluFunc;
        end
      end
      StBranch: begin
        aluop        = AluBr;
        pc_src       = 1'b1;
        pc_write     = zero;
        retire_pulse = 1'b1;
      end
      StTrap: begin
        // Held here until reset; flags remain set.
      end
      default: state_d = StIdle;
    endcase

    if (retire_pulse) begin
      retire_d = retire_q + 1'b1;
      state_d  = run ? StFetch : StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cls_q     <= ClsR;
      wait_q    <= '0;
      retire_q  <= '0;
      illegal_q <= 1'b0;
      bus_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      bus_q     <= bus_d;
    end
  end

  assign illegal_instr = illegal_q;
  assign bus_error     = bus_q;
  assign retire_count  = retire_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: a phase-script model checks every output each cycle, and
// directed scenarios pin latencies, traps, run handling and counter wrap with literal values.
module tb_multicycle_control_fsm;

  localparam int unsigned TO = 4;
  localparam int unsigned RW = 4;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam int HANG = 1000;

  // Model phases and classes.
  localparam int PNONE = 0, PF = 1, PD = 2, PE = 3, PM = 4, PW = 5, PB = 6;
  localparam int CR = 0, CI = 1, CLD = 2, CST = 3, CBR = 4, CILL = 5;

  logic          clk = 1'b0;
  logic          rst_n, run, zero, mem_ready;
  logic [6:0]    opcode;
  logic          mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src;
  logic [1:0]    aluop;
  logic          reg_write, mem_to_reg, illegal_instr, bus_error, retire_pulse;
  logic [RW-1:0] retire_count;

  always #5 clk = ~clk;

  multicycle_control_fsm #(
    .MEM_TIMEOUT(TO),
    .RETIRE_W   (RW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .opcode       (opcode),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .iord         (iord),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src      (alu_src),
    .aluop        (aluop),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .illegal_instr(illegal_instr),
    .bus_error    (bus_error),
    .retire_pulse (retire_pulse),
    .retire_count (retire_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      OP_R:    return CR;
      OP_I:    return CI;
      OP_LD:   return CLD;
      OP_ST:   return CST;
      OP_BR:   return CBR;
      default: return CILL;
    endcase
  endfunction

  // Model: each instruction is a script of phases, memory phases stretch while ready is low.
  int   m_q[$];
  bit   m_trap, m_ill, m_bus;
  int   m_cls, m_wait, m_cnt, ph;
  logic e_req, e_we, e_iord, e_irw, e_pcw, e_pcs, e_alus, e_rw, e_m2r, e_ret;
  logic [1:0]  e_aluop;
  logic [13:0] got_v, exp_v;

  initial begin
    m_trap = 0; m_ill = 0; m_bus = 0; m_cls = CR; m_wait = 0; m_cnt = 0;
    forever begin
      @(negedge clk);
      got_v = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src, aluop, reg_write,
               mem_to_reg, illegal_instr, bus_error, retire_pulse};
      if (!rst_n) begin
        m_q.delete();
        m_trap = 0; m_ill = 0; m_bus = 0; m_wait = 0; m_cnt = 0;
        chk("reset_ctrl", 32'(got_v), 32'd0);
        chk("reset_count", 32'(retire_count), 32'd0);
      end else begin
        ph = (m_trap || m_q.size() == 0) ? PNONE : m_q[0];
        {e_req, e_we, e_iord, e_irw, e_pcw, e_pcs, e_alus, e_rw, e_m2r, e_ret} = '0;
        e_aluop = 2'b00;
        case (ph)
          PF: begin
            e_req = 1; e_irw = mem_ready; e_pcw = mem_ready;
          end
          PE: begin
            e_alus  = (m_cls != CR);
            e_aluop = (m_cls == CR || m_cls == CI) ? 2'b10 : 2'b00;
          end
          PM: begin
            e_req = 1; e_iord = 1; e_alus = 1; e_we = (m_cls == CST);
            e_ret = (m_cls == CST) && mem_ready;
          end
          PW: begin
            e_rw = 1; e_m2r = (m_cls == CLD); e_ret = 1;
            if (m_cls == CR || m_cls == CI) begin
              e_alus  = (m_cls == CI);
              e_aluop = 2'b10;
            end
          end
          PB: begin
            e_aluop = 2'b01; e_pcs = 1; e_pcw = zero; e_ret = 1;
          end
          default: ;
        endcase
        exp_v = {e_req, e_we, e_iord, e_irw, e_pcw, e_pcs, e_alus, e_aluop, e_rw, e_m2r,
                 m_ill, m_bus, e_ret};
        chk($sformatf("ctrl_phase%0d", ph), 32'(got_v), 32'(exp_v));
        chk("count", 32'(retire_count), 32'(m_cnt));
        if (!m_trap) begin
          if (ph == PNONE) begin
            if (run) m_q.push_back(PF);
          end else if (ph == PF || ph == PM) begin
            if (mem_ready) begin
              void'(m_q.pop_front());
              m_wait = 0;
              if (ph == PF) m_q.push_back(PD);
            end else begin
              m_wait++;
              if (TO != 0 && m_wait >= int'(TO)) begin
                m_trap = 1; m_bus = 1; m_q.delete();
              end
            end
          end else if (ph == PD) begin
            void'(m_q.pop_front());
            m_cls = cls_of(opcode);
            case (m_cls)
              CR, CI:  begin m_q.push_back(PE); m_q.push_back(PW); end
              CLD:     begin m_q.push_back(PE); m_q.push_back(PM); m_q.push_back(PW); end
              CST:     begin m_q.push_back(PE); m_q.push_back(PM); end
              CBR:     m_q.push_back(PB);
              default: begin m_trap = 1; m_ill = 1; end
            endcase
          end else begin
            void'(m_q.pop_front());
          end
          if (e_ret) begin
            m_cnt = (m_cnt + 1) % (1 << RW);
            if (run) m_q.push_back(PF);
          end
        end
      end
    end
  end

  // Stimulus and memory responder.
  int         flat, mlat, rcnt;
  logic [6:0] nxt_op;
  logic       nxt_zero;
  bit         prev_fire, prev_fetch, present;

  task automatic tick();
    @(posedge clk);
    #1;
    if (present) begin
      opcode  = 7'h00;  // opcode is only guaranteed valid in the decode cycle
      present = 0;
    end
    if (prev_fire && prev_fetch) begin
      opcode  = nxt_op;
      zero    = nxt_zero;
      present = 1;
    end
    if (prev_fire || !mem_req || !rst_n) rcnt = 0;
    if (mem_req && rst_n) begin
      mem_ready = (rcnt >= (iord ? mlat : flat));
      rcnt++;
    end else begin
      mem_ready = 1'b0;
    end
    prev_fire  = mem_req && mem_ready && rst_n;
    prev_fetch = !iord;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    present = 0; prev_fire = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic go(input logic [6:0] op, input logic z, input int fl, input int ml,
                    output int cyc, output bit retired);
    bit started;
    started = 0;
    nxt_op = op; nxt_zero = z; flat = fl; mlat = ml;
    cyc = 0; retired = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (mem_req && !iord) started = 1;
      if (started) cyc++;
      if (retire_pulse) begin
        retired = 1;
        break;
      end
    end
  endtask

  int cyc, reqs;
  bit ret;

  initial begin
    rst_n = 0; run = 1; opcode = 7'h00; zero = 0; mem_ready = 0;
    flat = 0; mlat = 0; rcnt = 0; nxt_op = OP_R; nxt_zero = 0;
    prev_fire = 0; prev_fetch = 0; present = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_cnt", 32'(retire_count), 32'd0);

    // R-type with run held through reset, zero-wait memory.
    rst_n = 1;
    #1;
    chk("idle_req", 32'(mem_req), 32'd0);
    go(OP_R, 0, 0, 0, cyc, ret);
    chk("r_ret", 32'(ret), 32'd1);
    chk("r_lat", 32'(cyc), 32'd4);
    chk("r_wb_aluop", 32'(aluop), 32'd2);

    // Load with three memory wait cycles.
    go(OP_LD, 0, 0, 3, cyc, ret);
    chk("ld_ret", 32'(ret), 32'd1);
    chk("ld_lat", 32'(cyc), 32'd8);
    chk("ld_m2r", 32'(mem_to_reg), 32'd1);

    // Store, taken branch, untaken branch.
    do_reset();
    go(OP_ST, 0, 0, 0, cyc, ret);
    chk("st_lat", 32'(cyc), 32'd4);
    chk("st_we", 32'(mem_we), 32'd1);
    go(OP_BR, 1, 0, 0, cyc, ret);
    chk("br1_lat", 32'(cyc), 32'd3);
    chk("br1_pcw", 32'({pc_write, pc_src}), 32'd3);
    go(OP_BR, 0, 0, 0, cyc, ret);
    chk("br0_lat", 32'(cyc), 32'd3);
    chk("br0_pcw", 32'({pc_write, pc_src}), 32'd1);
    run = 0;
    tick();
    chk("br_cnt", 32'(retire_count), 32'd3);
    chk("br_idle", 32'(mem_req), 32'd0);

    // run dropped during EXECUTE of an I-type.
    run = 1; nxt_op = OP_I; nxt_zero = 0; flat = 0;
    tick();  // FETCH
    tick();  // DECODE
    tick();  // EXECUTE
    chk("i_exe", 32'({alu_src, aluop}), 32'b110);
    run = 0;
    tick();  // WRITEBACK
    chk("i_ret", 32'(retire_pulse), 32'd1);
    tick();
    chk("i_idle_req", 32'(mem_req), 32'd0);
    chk("i_idle_cnt", 32'(retire_count), 32'd4);
    tick();
    chk("i_idle2", 32'(mem_req), 32'd0);
    run = 1;
    tick();
    chk("i_refetch", 32'({mem_req, iord}), 32'b10);
    go(OP_I, 0, 0, 0, cyc, ret);
    chk("i2_ret", 32'(ret), 32'd1);

    // Illegal opcode traps, no retire, cleared only by reset.
    go(OP_BAD, 0, 0, 0, cyc, ret);
    chk("ill_noret", 32'(ret), 32'd0);
    chk("ill_flag", 32'({illegal_instr, bus_error}), 32'b10);
    chk("ill_cnt", 32'(retire_count), 32'd5);
    rst_n = 0;
    #1;
    chk("ill_clear", 32'(illegal_instr), 32'd0);
    do_reset();

    // Fetch timeout: four waiting cycles then trap.
    flat = HANG; reqs = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_req) reqs++;
    end
    chk("to_reqs", 32'(reqs), 32'd4);
    chk("to_flag", 32'({illegal_instr, bus_error}), 32'b01);

    // Reset while a fetch is pending drops the request at once.
    do_reset();
    flat = HANG;
    tick();
    chk("midrst_pre", 32'(mem_req), 32'd1);
    rst_n = 0;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    do_reset();

    // Ready on the threshold cycle wins.
    go(OP_R, 0, 3, 0, cyc, ret);
    chk("to_edge_ret", 32'(ret), 32'd1);
    chk("to_edge_lat", 32'(cyc), 32'd7);
    chk("to_edge_flag", 32'(bus_error), 32'd0);

    // Memory-phase timeout on a load.
    go(OP_LD, 0, 0, HANG, cyc, ret);
    chk("mto_noret", 32'(ret), 32'd0);
    chk("mto_flag", 32'(bus_error), 32'd1);

    // retire_count wraps modulo 2^RW.
    do_reset();
    for (int i = 0; i < 16; i++) go(OP_BR, i[0], 0, 0, cyc, ret);
    run = 0;
    tick();
    chk("wrap0", 32'(retire_count), 32'd0);
    run = 1;
    go(OP_BR, 0, 0, 0, cyc, ret);
    run = 0;
    tick();
    chk("wrap1", 32'(retire_count), 32'd1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
